// File: rtl/delay_chain_out_fifo.sv
// delay_chain_out_fifo
//   First-word-fall-through output buffer placed after the configurable
//   delay chain. Captures the chain's delayed word and valid bit, presents
//   them on a valid/ready stream, and drives the chain enable so the whole
//   chain freezes (rather than drops or repeats words) as the buffer fills.
//   Optional feature macro: DCOF_STALL_CNT_EN adds a saturating 16-bit
//   counter of cycles where a valid word was held back by the stall.
module delay_chain_out_fifo #(
  parameter int BITWIDTH  = 4,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [BITWIDTH-1:0]       in_data,
  output logic                      chain_enable,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BITWIDTH-1:0]       out_data,
`ifdef DCOF_STALL_CNT_EN
  output logic [15:0]               stall_cycles,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Highest occupancy at which the chain may still advance; keeps
  // AF_MARGIN entries free as headroom.
  localparam logic [CW-1:0] EN_MAX = CW'(DEPTH - 1 - AF_MARGIN);

  logic [BITWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  logic                push, pop;

  // Handshake decode and next-state for pointers and occupancy; flush wins
  // over any coincident push or pop.
  always_comb begin
    chain_enable = run && !flush && (count_q <= EN_MAX);
    out_valid    = (count_q != '0);
    push         = in_valid && chain_enable;
    pop          = out_valid && out_ready;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; buffered words are lost at once on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Fall-through read of the head entry.
  assign out_data = mem_q[rd_ptr_q];
  assign count    = count_q;

`ifdef DCOF_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles where the chain holds a valid word because it is frozen.
  always_comb begin
    stall_d = stall_q;
    if (flush)
      stall_d = '0;
    else if (in_valid && !chain_enable && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_delay_chain_out_fifo.sv
// Testbench for delay_chain_out_fifo: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_delay_chain_out_fifo;

  localparam int BW    = 4;
  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          run, flush, in_valid, out_ready;
  logic [BW-1:0] in_data;
  wire           chain_enable, out_valid;
  wire [BW-1:0]  out_data;
  wire [CW-1:0]  count;
`ifdef DCOF_STALL_CNT_EN
  wire [15:0]    stall_cycles;
`endif

  delay_chain_out_fifo #(.BITWIDTH(BW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .chain_enable (chain_enable),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef DCOF_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue, stall counter as an integer.
  logic [BW-1:0] mq[$];
  int unsigned   m_stall = 0;

  function automatic bit model_en();
    return run && !flush && (mq.size() <= DEPTH - 1 - AFM);
  endfunction

  // Advance one clock edge and apply the specification's rules to the model.
  task automatic tick();
    bit en, push, pop;
    en   = model_en();
    push = in_valid && en;
    pop  = (mq.size() != 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (in_valid && !en && m_stall < 32'hFFFF) m_stall++;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0;
    mq.delete(); m_stall = 0;
    #12;
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (chain_enable !== 1'b1) begin errors++; $display("FAIL reset_enable_run1: got %b expected 1", chain_enable); end
    run = 1'b0; #1;
    checks++; if (chain_enable !== 1'b0) begin errors++; $display("FAIL reset_enable_run0: got %b expected 0", chain_enable); end
    run = 1'b1;
`ifdef DCOF_STALL_CNT_EN
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_basic_flow();
    logic [BW-1:0] words [3];
    words[0] = 4'h3; words[1] = 4'h7; words[2] = 4'hA;
    run = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_data !== words[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, out_data, words[i]); end
      checks++; if (count !== CW'(1)) begin errors++; $display("FAIL basic_count[%0d]: got %0d expected 1", i, count); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL basic_empty: got %0d expected 0", count); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    run = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bit en;
      in_data = BW'(k);
      en = model_en();
      tick();
      if (en) k++;
      if (cyc >= 6) begin
        checks++; if (chain_enable !== 1'b0) begin errors++; $display("FAIL bp_stalled[%0d]: got %b expected 0", cyc, chain_enable); end
      end
    end
    checks++; if (count !== CW'(7)) begin errors++; $display("FAIL bp_count: got %0d expected 7", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== BW'(i)) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, BW'(i)); end
      tick();
      if (i == 0) begin
        checks++; if (chain_enable !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b expected 1", chain_enable); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    run = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = BW'(i);
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_data = BW'(6 + j);
      #1;
      checks++; if (count !== CW'(6)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 6", j, count); end
      checks++; if (chain_enable !== 1'b1) begin errors++; $display("FAIL b2b_enable[%0d]: got %b expected 1", j, chain_enable); end
      checks++; if (out_data !== BW'(j)) begin errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", j, out_data, BW'(j)); end
      tick();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== BW'(20 + j)) begin errors++; $display("FAIL b2b_tail[%0d]: got v=%b d=%h expected v=1 d=%h", j, out_valid, out_data, BW'(20 + j)); end
      tick();
    end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL b2b_empty: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    run = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = BW'(9 + i);
      tick();
    end
    flush = 1'b1; in_data = 4'hF;
    #1;
    checks++; if (chain_enable !== 1'b0) begin errors++; $display("FAIL flush_enable: got %b expected 0", chain_enable); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    in_valid = 1'b1; in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== CW'(1) || out_data !== 4'h5) begin errors++; $display("FAIL flush_after: got c=%0d d=%h expected c=1 d=5", count, out_data); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    run = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = BW'(i + 2);
      tick();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
    mq.delete(); m_stall = 0;
    #2 reset_n = 1'b1;
    #1;
    checks++; if (chain_enable !== 1'b1) begin errors++; $display("FAIL areset_enable: got %b expected 1", chain_enable); end
  endtask

  task automatic test_random();
    in_valid = 1'b0; flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit en;
      run       = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      checks++; if (chain_enable !== model_en()) begin errors++; $display("FAIL rnd_enable[%0d]: got %b expected %b", c, chain_enable, model_en()); end
      checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, count, mq.size()); end
      checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, out_data, mq[0]); end
      end
`ifdef DCOF_STALL_CNT_EN
      checks++; if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", c, stall_cycles, m_stall); end
`endif
      en = model_en();
      tick();
      // A frozen chain keeps presenting the same word and valid bit.
      if (en) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = BW'($urandom);
      end
    end
    flush = 1'b0;
  endtask

`ifdef DCOF_STALL_CNT_EN
  task automatic test_stall_cnt();
    flush = 1'b1; in_valid = 1'b0; tick();
    flush = 1'b0; run = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (stall_cycles !== 16'd10) begin errors++; $display("FAIL stall_ten: got %0d expected 10", stall_cycles); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL stall_flush: got %0d expected 0", stall_cycles); end
    for (int i = 0; i < 65534; i++) tick();
    checks++; if (stall_cycles !== 16'hFFFE) begin errors++; $display("FAIL stall_fffe: got %h expected fffe", stall_cycles); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h expected ffff", stall_cycles); end
    in_valid = 1'b0; run = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_flow();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
`ifdef DCOF_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_chain_out_fifo.md
# delay_chain_out_fifo

Output buffer that sits directly downstream of the configurable delay chain. It captures the chain's delayed data word and its matching delayed valid bit into a small first-word-fall-through FIFO, and presents them on a valid/ready stream. It also generates the chain's `enable`, so the whole chain freezes when the buffer nears full instead of dropping or duplicating words.

## Interface
Parameters:
- `BITWIDTH`, 4, data word width; must match the delay chain.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 4.
- `AF_MARGIN`, 1, free entries kept in reserve before the chain is stalled; 0 ≤ AF_MARGIN ≤ DEPTH-2.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  global run request; 0 stalls the chain regardless of fill level.
- `flush`  in  1  synchronous FIFO clear.
- `in_valid`  in  1  delayed valid bit (1-bit delay chain running in parallel with data).
- `in_data`  in  BITWIDTH  delay chain `q`.
- `chain_enable`  out  1  drives the delay chain `enable`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  BITWIDTH  head-of-FIFO word.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- `chain_enable = run && !flush && (count <= DEPTH-1-AF_MARGIN)`.
  - Decoded from registered state and inputs only.
  - No path from `out_ready`.
- Push when `in_valid && chain_enable`:
  - Writes `in_data` at `wr_ptr`; `wr_ptr` increments mod DEPTH.
  - While `chain_enable`=0 the chain holds `q`, so the held word is never written twice.
- Pop when `out_valid && out_ready`: `rd_ptr` increments mod DEPTH.
- `out_valid = (count != 0)`.
- `out_data = mem[rd_ptr]`, a combinational read of the registered array (FWFT).
- `count` update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including when `count` = DEPTH-1-AF_MARGIN.
- Pointers wrap from DEPTH-1 to 0 with no gap or skipped entry.
- Push while full is impossible by construction (`chain_enable`=0 when `count` ≥ DEPTH-AF_MARGIN).
- Pop while empty is ignored.
- `flush`=1:
  - Next edge sets `wr_ptr`, `rd_ptr` and `count` to 0.
  - A coincident push or pop is discarded; flush wins.
  - `chain_enable` is 0 in the flush cycle.
- Array contents are not reset. Only pointers and `count` are reset.

## Timing
- Reset values:
  - `count`=0, `out_valid`=0.
  - `out_data` undefined (don't-care while `out_valid`=0).
  - `chain_enable` = `run` (FIFO empty).
- Reset mid-operation: all buffered words are lost immediately (asynchronous); the delay chain is reset by the same `reset_n`.
- Latency from push edge to the word appearing on `out_data` with `out_valid`=1 (FIFO previously empty): 0 cycles after the edge, i.e. visible in the following cycle.
- `chain_enable` reflects the new `count` in the cycle after the push or pop that changed it.
- Stall: `chain_enable` drops in the cycle after `count` reaches DEPTH-AF_MARGIN.
- Resume: `chain_enable` rises in the cycle after a pop brings `count` to DEPTH-1-AF_MARGIN.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro `DCOF_STALL_CNT_EN`.
- Defined:
  - Adds output `stall_cycles` [15:0], reset to 0.
  - Increments each cycle that `in_valid`=1 and `chain_enable`=0.
  - Saturates at 16'hFFFF.
  - Cleared by `flush`.
- Undefined: port and counter are absent; no other behaviour changes.

## Test plan
- Basic flow: reset, `run`=1, `out_ready`=1, push 0x3, 0x7, 0xA on consecutive cycles.
  - Required: `out_data` 0x3, 0x7, 0xA in order, one cycle after each push.
  - Required: `count` never exceeds 1.
- Backpressure (DEPTH=8, AF_MARGIN=1), `out_ready`=0, continuous `in_valid`=1, data 0..6.
  - Required: `count` reaches 7.
  - Required: `chain_enable` is 0 from the next cycle.
  - Required: exactly 7 words stored.
  - Then `out_ready`=1: 0..6 drain in order, `chain_enable` returns to 1 after the first pop, and no word is duplicated.
- Simultaneous push and pop at `count`=6.
  - Required: `count` stays 6 and `chain_enable` stays 1.
  - Required: wrap-around across 20 words preserves order.
- Flush with coincident push at `count`=4.
  - Required: next cycle `count`=0 and `out_valid`=0.
  - Required: pushed word absent; `chain_enable`=0 during the flush cycle.
- Asynchronous reset with `count`=5, asserted mid-cycle.
  - Required: `count`=0 and `out_valid`=0 immediately, before the next edge.
  - Required: after release, `chain_enable`=`run`.
- With `DCOF_STALL_CNT_EN`:
  - `run`=0 and `in_valid`=1 for 10 cycles → `stall_cycles`=10.
  - `flush` → 0.
  - Forced to 16'hFFFE, then 3 stall cycles → holds at 16'hFFFF.
